// File: rtl/alu_pkg.sv
// alu_pkg: opcode codes and FSM states shared by the sequential ALU.
package alu_pkg;
    localparam logic [31:0] OP_NOPE  = 32'd0;
    localparam logic [31:0] OP_LOADI = 32'd1;
    localparam logic [31:0] OP_LOAD  = 32'd2;
    localparam logic [31:0] OP_STORE = 32'd3;
    localparam logic [31:0] OP_INC   = 32'd4;
    localparam logic [31:0] OP_DEC   = 32'd5;
    localparam logic [31:0] OP_SNIB  = 32'd6;
    localparam logic [31:0] OP_SNIE  = 32'd7;
    localparam logic [31:0] OP_MOVE  = 32'd8;
    localparam logic [31:0] OP_BUN   = 32'd9;
    localparam logic [31:0] OP_HALT  = 32'd10;
    localparam logic [31:0] OP_SNIEV = 32'd11;
    localparam logic [31:0] OP_SNIOD = 32'd12;
    localparam logic [31:0] OP_RESET = 32'd13;
    localparam logic [31:0] OP_ADD   = 32'd14;
    localparam logic [31:0] OP_SNIZ  = 32'd15;
    localparam logic [31:0] OP_MUL   = 32'd16;
    localparam logic [31:0] OP_SHL   = 32'd17;
    localparam logic [31:0] OP_SHR   = 32'd18;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operation request/result handshake bundle between controller and ALU.
interface alu_seq_if #(parameter int WIDTH = 16, parameter int OPCODE_WIDTH = 5);
    logic                    in_valid, in_ready, out_valid, out_ready;
    logic                    flag_zero, flag_carry, flag_skip;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [WIDTH-1:0]        alu_input1, alu_input2, alu_output;
    modport master (output in_valid, opcode, alu_input1, alu_input2, out_ready,
                    input  in_ready, out_valid, alu_output, flag_zero, flag_carry, flag_skip);
    modport slave  (input  in_valid, opcode, alu_input1, alu_input2, out_ready,
                    output in_ready, out_valid, alu_output, flag_zero, flag_carry, flag_skip);
endinterface

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, one multiplier bit per cycle, WIDTH cycles.
module alu_seq_mul #(parameter int WIDTH = 16) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0]    cnt;
    logic             run;
    logic [WIDTH-1:0] mcand, mplier, acc;
    // product is the accumulator plus the current partial term, final on the last step
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = run && cnt == CW'(WIDTH - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt    <= '0;
            run    <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            run    <= !done;
        end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags; MUL runs iteratively, all else in one cycle.
module alu_seq import alu_pkg::*; #(
    parameter int WIDTH        = 16,
    parameter int OPCODE_WIDTH = 5,
    parameter int SHAMT_WIDTH  = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);
    state_t           state, state_n;
    logic [WIDTH-1:0] a, b, res_c, res_q, product;
    logic [WIDTH:0]   add_w, inc_w, dec_w;
    logic [31:0]      op;
    logic             carry_c, skip_c, carry_q, skip_q, zero_q, accept, is_mul, mul_done;
    assign a              = bus.alu_input1;
    assign b              = bus.alu_input2;
    assign op             = 32'(bus.opcode);
    assign is_mul         = op == OP_MUL;
    assign bus.in_ready   = state == IDLE || (state == DONE && bus.out_ready);
    assign accept         = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = state == DONE;
    assign bus.alu_output = res_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_carry = carry_q;
    assign bus.flag_skip  = skip_q;
    assign add_w          = {1'b0, a} + {1'b0, b};
    assign inc_w          = {1'b0, a} + (WIDTH + 1)'(1);
    assign dec_w          = {1'b0, a} - (WIDTH + 1)'(1);
    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk(clk), .rst(rst), .start(accept && is_mul),
        .a(a), .b(b), .done(mul_done), .product(product)
    );
    always_comb begin
        res_c   = '1;
        carry_c = 1'b0;
        skip_c  = 1'b0;
        case (op)
            OP_STORE: res_c = a;
            OP_MOVE:  res_c = b;
            OP_INC:   {carry_c, res_c} = inc_w;
            OP_DEC:   {carry_c, res_c} = dec_w;
            OP_ADD:   {carry_c, res_c} = add_w;
            OP_RESET: res_c = '0;
            OP_SNIB:  skip_c = a > b;
            OP_SNIE:  skip_c = a == b;
            OP_SNIEV: skip_c = !a[0];
            OP_SNIOD: skip_c = a[0];
            OP_SNIZ:  skip_c = a == '0;
            OP_SHL:   res_c = a << b[SHAMT_WIDTH-1:0];
            OP_SHR:   res_c = a >> b[SHAMT_WIDTH-1:0];
            default:  ;
        endcase
        // skip ops report the condition in the MSB above an all-ones field
        if (skip_c) res_c = '1;
        else if (op == OP_SNIB || op == OP_SNIE || op == OP_SNIEV || op == OP_SNIOD || op == OP_SNIZ)
            res_c[WIDTH-1] = 1'b0;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? (is_mul ? BUSY : DONE) : IDLE;
            BUSY:    state_n = mul_done ? DONE : BUSY;
            DONE:    state_n = !bus.out_ready ? DONE : accept ? (is_mul ? BUSY : DONE) : IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            skip_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept && !is_mul) begin
            res_q   <= res_c;
            carry_q <= carry_c;
            skip_q  <= skip_c;
            zero_q  <= res_c == '0;
        end else if (mul_done) begin
            res_q   <= product;
            carry_q <= 1'b0;
            skip_q  <= 1'b0;
            zero_q  <= product == '0;
        end
endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, parametrised successor to the processor's combinational ALU. Accepts one operation per valid/ready handshake, registers the result, and adds an iterative multiplier, barrel shifts and a flag output (zero, carry, skip) on top of the existing opcode set. Sits between the register-read stage and write-back of the state-machine MIPS core; the controller stalls on `in_ready`/`out_valid` instead of assuming single-cycle execution.

## Interface
- `WIDTH`, 16: operand/result width, ≥ 4, power of two.
- `OPCODE_WIDTH`, 5: opcode field width; must hold codes 0–18.
- `SHAMT_WIDTH`, $clog2(WIDTH): shift-amount bits taken from `alu_input2`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  block can accept an operation this cycle.
- `opcode`  in  OPCODE_WIDTH  operation code.
- `alu_input1`  in  WIDTH  operand A.
- `alu_input2`  in  WIDTH  operand B.
- `out_valid`  out  1  result/flags valid.
- `out_ready`  in  1  consumer takes result this cycle.
- `alu_output`  out  WIDTH  registered result.
- `flag_zero`  out  1  result == 0.
- `flag_carry`  out  1  carry-out (ADD, INC) or borrow (DEC); 0 otherwise.
- `flag_skip`  out  1  skip condition for SNIx ops; 0 otherwise.

## Operation
- Opcodes 0–15 unchanged: NOPE 0, LOADI 1, LOAD 2, STORE 3, INC 4, DEC 5, SNIB 6, SNIE 7, MOVE 8, BUN 9, HALT 10, SNIEV 11, SNIOD 12, RESET 13, ADD 14, SNIZ 15. New: MUL 16, SHL 17, SHR 18.
- Default result all ones: NOPE, LOADI, LOAD, BUN, HALT and any undefined code (19–31).
- STORE → A; MOVE → B; INC → A+1; DEC → A−1; ADD → A+B; RESET → 0 (all modulo 2^WIDTH).
- SNIB (A>B, unsigned), SNIE (A==B), SNIEV (A[0]==0), SNIOD (A[0]==1), SNIZ (A==0): result = {cond, all ones below}; `flag_skip` = cond.
- SHL/SHR: logical shift of A by B[SHAMT_WIDTH-1:0]; upper bits of B ignored.
- MUL: unsigned shift-add, one multiplier bit per cycle; result = low WIDTH bits of A×B; `flag_carry` = 0.
- `flag_zero` computed on the final registered result for every opcode.
- FSM states: IDLE, BUSY (MUL iterating), DONE (result held).
  - IDLE, accept, non-MUL → DONE; accept, MUL → BUSY.
  - BUSY, iteration counter reaches WIDTH−1 → DONE.
  - DONE, `out_ready`=1 and new accept → DONE (non-MUL) or BUSY (MUL); `out_ready`=1 no accept → IDLE; `out_ready`=0 → hold.
- `in_ready` = (IDLE) or (DONE and `out_ready`). Accept = `in_valid` & `in_ready`. Operands and opcode captured on accept; later input changes ignored.

## Timing
- Reset (async, any state incl. mid-MUL): state IDLE, `in_ready`=1 once released, `out_valid`=0, `alu_output`=0, all flags 0, iteration counter 0.
- Non-MUL latency 1: accept at edge N, `out_valid`=1 after edge N.
- MUL latency WIDTH: `out_valid` rises WIDTH edges after accept; `in_ready`=0 throughout BUSY.
- Back-to-back non-MUL throughput 1 op/cycle while `out_ready`=1.
- `out_valid` and outputs stable while `out_ready`=0 (no drop, no overwrite).
- `in_valid` asserted during BUSY: not accepted, no effect.

## Structure
- Package `alu_pkg`: opcode localparams (0–18), FSM state enum IDLE/BUSY/DONE.
- Sub-module `alu_seq_mul`: iterative multiplier (start, A, B → done, product), WIDTH-cycle, counter and accumulator internal; everything else inline.

## Test plan
- Reset then ADD 0xFFFF+0x0001 (WIDTH=16) → one cycle later `out_valid`=1, result 0x0000, `flag_zero`=1, `flag_carry`=1.
- SNIB A=5,B=3 → result 0xFFFF, `flag_skip`=1; SNIB A=3,B=5 → 0x7FFF, `flag_skip`=0.
- MUL 0x0123×0x0010 → `out_valid` exactly 16 cycles after accept, result 0x1230, `in_ready`=0 meanwhile.
- SHL A=0x0001, B=0x0013 → shift 3, result 0x0008; SHR A=0x8000, B=15 → 0x0001.
- Back-pressure: INC A=7 with `out_ready`=0 for 5 cycles → result 8 held, `in_ready`=0, next in_valid ignored; release → new op accepted same cycle.
- Assert `rst` mid-MUL (cycle 8) → `out_valid`=0, `alu_output`=0 immediately; after release, DEC 0 → 0xFFFF, `flag_carry`=1.
